// File: rtl/mpc_mac_pipe_dsp_if.sv
// mpc_mac_pipe_dsp_if: sample and result bus of the pipelined signed MAC.
//
// Valid semantics: a sample is accepted on every rising edge where
// in_valid=1 and ce=1. There is no ready signal and no back-pressure.
// The results p/ovf are meaningful only in cycles where out_valid=1.
// Between valid results they hold their last value.
//
//   master : drives in_valid, a, b, acc_en, acc_clr; observes out_valid, p, ovf
//   slave  : the MAC itself (the mirror image of master)
interface mpc_mac_pipe_dsp_if #(
  parameter int A_W   = 21,
  parameter int B_W   = 14,
  parameter int OUT_W = 35
);
  logic                    in_valid;
  logic signed [A_W-1:0]   a;
  logic signed [B_W-1:0]   b;
  logic                    acc_en;
  logic                    acc_clr;
  logic                    out_valid;
  logic signed [OUT_W-1:0] p;
  logic                    ovf;

  modport master (
    output in_valid, a, b, acc_en, acc_clr,
    input  out_valid, p, ovf
  );

  modport slave (
    input  in_valid, a, b, acc_en, acc_clr,
    output out_valid, p, ovf
  );
endinterface

// File: rtl/mpc_mac_pipe_dsp.sv
// mpc_mac_pipe_dsp: four-stage pipelined signed multiply-accumulate.
//
// S1 registers the sample.
// S2 forms the full-precision product.
// S3 loads the product into the saturating accumulator or adds it.
// S4 applies a round-half-up arithmetic right shift and saturates to OUT_W.
//
// Ports:
//   clk  - clock; all state changes on the rising edge
//   rst  - synchronous active-low reset; it takes priority over ce
//   ce   - clock enable; when low, every register holds
//   bus  - sample inputs and result outputs (mpc_mac_pipe_dsp_if.slave)
module mpc_mac_pipe_dsp #(
  parameter int A_W   = 21,
  parameter int B_W   = 14,
  parameter int ACC_W = 48,
  parameter int OUT_W = 35,
  parameter int SHIFT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  mpc_mac_pipe_dsp_if.slave   bus
);

  // Rounding constant 2^(SHIFT-1). The shift amount is clamped so SHIFT=0 stays legal.
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W:0] RND_K = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;

  // S1
  logic                    s1_valid_q, s1_valid_d;
  logic signed [A_W-1:0]   s1_a_q, s1_a_d;
  logic signed [B_W-1:0]   s1_b_q, s1_b_d;
  logic                    s1_en_q, s1_en_d;
  logic                    s1_clr_q, s1_clr_d;
  // S2
  logic                    s2_valid_q, s2_valid_d;
  logic signed [ACC_W-1:0] s2_prod_q, s2_prod_d;
  logic                    s2_en_q, s2_en_d;
  logic                    s2_clr_q, s2_clr_d;
  // S3
  logic                    s3_valid_q, s3_valid_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    acc_sat_q, acc_sat_d;
  // S4
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] p_q, p_d;
  logic                    ovf_q, ovf_d;

  logic signed [A_W+B_W-1:0]     prod;
  logic        [ACC_W:0]         sum;
  logic                          sum_ovf;
  logic signed [ACC_W:0]         ext_rnd;
  logic signed [ACC_W:0]         rnd;
  logic        [ACC_W-OUT_W+1:0] rnd_hi;
  logic                          in_range;

  always_comb begin
    // S1: the mode bits only mean something for a valid sample.
    s1_valid_d = bus.in_valid;
    s1_a_d     = bus.a;
    s1_b_d     = bus.b;
    s1_en_d    = bus.in_valid & bus.acc_en;
    s1_clr_d   = bus.in_valid & bus.acc_clr;

    // S2: the full product fits in A_W+B_W bits, then it is sign-extended.
    prod       = s1_a_q * s1_b_q;
    s2_prod_d  = ACC_W'(prod);
    s2_valid_d = s1_valid_q;
    s2_en_d    = s1_en_q;
    s2_clr_d   = s1_clr_q;

    // S3: one guard bit detects signed overflow of the running sum.
    sum        = {acc_q[ACC_W-1], acc_q} + {s2_prod_q[ACC_W-1], s2_prod_q};
    sum_ovf    = sum[ACC_W] ^ sum[ACC_W-1];
    s3_valid_d = s2_valid_q;
    acc_d      = acc_q;
    acc_sat_d  = acc_sat_q;
    if (s2_valid_q) begin
      if (!s2_en_q || s2_clr_q) begin
        // A load cannot overflow because ACC_W >= A_W+B_W. It also clears the sticky flag.
        acc_d     = s2_prod_q;
        acc_sat_d = 1'b0;
      end else begin
        if (sum_ovf) begin
          // sum[ACC_W] is the true sign of the sum, so it selects the bound.
          acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
        acc_sat_d = acc_sat_q | sum_ovf;
      end
    end

    // S4: round in ACC_W+1 bits so the rounding add cannot wrap, then clamp.
    ext_rnd     = $signed({acc_q[ACC_W-1], acc_q} + RND_K);
    rnd         = ext_rnd >>> SHIFT;
    rnd_hi      = rnd[ACC_W:OUT_W-1];
    in_range    = (&rnd_hi) | ~(|rnd_hi);
    out_valid_d = s3_valid_q;
    p_d         = p_q;
    ovf_d       = ovf_q;
    if (s3_valid_q) begin
      if (in_range) begin
        p_d = rnd[OUT_W-1:0];
      end else begin
        p_d = rnd[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
      ovf_d = ~in_range | acc_sat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_en_q     <= 1'b0;
      s1_clr_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_en_q     <= 1'b0;
      s2_clr_q    <= 1'b0;
      s3_valid_q  <= 1'b0;
      acc_q       <= '0;
      acc_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
    end else if (ce) begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_en_q     <= s1_en_d;
      s1_clr_q    <= s1_clr_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_en_q     <= s2_en_d;
      s2_clr_q    <= s2_clr_d;
      s3_valid_q  <= s3_valid_d;
      acc_q       <= acc_d;
      acc_sat_q   <= acc_sat_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mpc_mac_pipe_dsp.sv
// tb_mpc_mac_pipe_dsp: directed bench for mpc_mac_pipe_dsp.
// u0 uses the default parameters. u1 uses SHIFT=4 and is used for the rounding cases.
module tb_mpc_mac_pipe_dsp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce  = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  mpc_mac_pipe_dsp_if #(.A_W(21), .B_W(14), .OUT_W(35)) if0 ();
  mpc_mac_pipe_dsp_if #(.A_W(21), .B_W(14), .OUT_W(35)) if1 ();

  mpc_mac_pipe_dsp #(.A_W(21), .B_W(14), .ACC_W(48), .OUT_W(35), .SHIFT(0)) u0 (
    .clk(clk), .rst(rst), .ce(ce), .bus(if0)
  );
  mpc_mac_pipe_dsp #(.A_W(21), .B_W(14), .ACC_W(48), .OUT_W(35), .SHIFT(4)) u1 (
    .clk(clk), .rst(rst), .ce(ce), .bus(if1)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive0(input bit v, input longint a, input longint b, input bit en, input bit clr);
    if0.in_valid = v;
    if0.a        = 21'(a);
    if0.b        = 14'(b);
    if0.acc_en   = en;
    if0.acc_clr  = clr;
  endtask

  task automatic drive1(input bit v, input longint a, input longint b, input bit en, input bit clr);
    if1.in_valid = v;
    if1.a        = 21'(a);
    if1.b        = 14'(b);
    if1.acc_en   = en;
    if1.acc_clr  = clr;
  endtask

  task automatic idle(input int n);
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(2);
    checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", if0.out_valid); end
    checks++; if (if0.p !== 35'sd0) begin failures++; $display("FAIL reset_p got=%0d exp=0", if0.p); end
    checks++; if (if0.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", if0.ovf); end
    checks++; if (if1.p !== 35'sd0) begin failures++; $display("FAIL reset_p_u1 got=%0d exp=0", if1.p); end
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_plain_mult();
    drive0(1, -3, 5, 0, 0);
    tick();
    idle(3);
    checks++; if (if0.out_valid !== 1'b1) begin failures++; $display("FAIL mult_valid got=%0b exp=1", if0.out_valid); end
    checks++; if (if0.p !== -35'sd15) begin failures++; $display("FAIL mult_p got=%0d exp=-15", if0.p); end
    checks++; if (if0.ovf !== 1'b0) begin failures++; $display("FAIL mult_ovf got=%0b exp=0", if0.ovf); end
    tick();
    checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL mult_valid_drop got=%0b exp=0", if0.out_valid); end
    checks++; if (if0.p !== -35'sd15) begin failures++; $display("FAIL mult_p_hold got=%0d exp=-15", if0.p); end
    idle(2);
  endtask

  task automatic test_accumulate(input bit bubble);
    bit     ev;
    longint ep;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: drive0(1, 2, 3, 1, 1);
        1: drive0(1, 4, 5, 1, 0);
        2: if (bubble) drive0(0, 0, 0, 0, 0); else drive0(1, -1, 7, 1, 0);
        3: if (bubble) drive0(1, -1, 7, 1, 0); else drive0(0, 0, 0, 0, 0);
        default: drive0(0, 0, 0, 0, 0);
      endcase
      tick();
      ev = 1'b0; ep = 0;
      if (!bubble) begin
        case (c)
          3: begin ev = 1; ep = 6;  end
          4: begin ev = 1; ep = 26; end
          5: begin ev = 1; ep = 19; end
          6, 7: ep = 19;
          default: ;
        endcase
      end else begin
        case (c)
          3: begin ev = 1; ep = 6;  end
          4: begin ev = 1; ep = 26; end
          5: ep = 26;
          6: begin ev = 1; ep = 19; end
          7: ep = 19;
          default: ;
        endcase
      end
      checks++;
      if (if0.out_valid !== ev) begin failures++; $display("FAIL acc_valid bubble=%0b c=%0d got=%0b exp=%0b", bubble, c, if0.out_valid, ev); end
      if (c >= 3) begin
        checks++;
        if (if0.p !== 35'(ep)) begin failures++; $display("FAIL acc_p bubble=%0b c=%0d got=%0d exp=%0d", bubble, c, if0.p, ep); end
      end
      if (ev) begin
        checks++;
        if (if0.ovf !== 1'b0) begin failures++; $display("FAIL acc_ovf bubble=%0b c=%0d got=%0b exp=0", bubble, c, if0.ovf); end
      end
    end
  endtask

  task automatic test_saturation();
    drive0(1, -(64'sd1 <<< 20), -(64'sd1 <<< 13), 1, 1); tick();
    drive0(1, -(64'sd1 <<< 20), -(64'sd1 <<< 13), 1, 0); tick();
    drive0(1, 1, 1, 0, 0); tick();
    drive0(0, 0, 0, 0, 0); tick();
    checks++; if (if0.out_valid !== 1'b1 || if0.p !== 35'sd8589934592) begin failures++; $display("FAIL sat_first_p got=%0d/%0b exp=8589934592/1", if0.p, if0.out_valid); end
    checks++; if (if0.ovf !== 1'b0) begin failures++; $display("FAIL sat_first_ovf got=%0b exp=0", if0.ovf); end
    tick();
    checks++; if (if0.out_valid !== 1'b1 || if0.p !== 35'sd17179869183) begin failures++; $display("FAIL sat_second_p got=%0d/%0b exp=17179869183/1", if0.p, if0.out_valid); end
    checks++; if (if0.ovf !== 1'b1) begin failures++; $display("FAIL sat_second_ovf got=%0b exp=1", if0.ovf); end
    tick();
    checks++; if (if0.out_valid !== 1'b1 || if0.p !== 35'sd1) begin failures++; $display("FAIL sat_reload_p got=%0d/%0b exp=1/1", if0.p, if0.out_valid); end
    checks++; if (if0.ovf !== 1'b0) begin failures++; $display("FAIL sat_reload_ovf got=%0b exp=0", if0.ovf); end
    idle(2);
  endtask

  task automatic test_rounding();
    drive1(1, 25, 1, 0, 0);  tick();
    drive1(1, -24, 1, 0, 0); tick();
    drive1(1, -25, 1, 0, 0); tick();
    drive1(0, 0, 0, 0, 0);   tick();
    checks++; if (if1.out_valid !== 1'b1 || if1.p !== 35'sd2) begin failures++; $display("FAIL round_25 got=%0d/%0b exp=2/1", if1.p, if1.out_valid); end
    tick();
    checks++; if (if1.out_valid !== 1'b1 || if1.p !== -35'sd1) begin failures++; $display("FAIL round_m24 got=%0d/%0b exp=-1/1", if1.p, if1.out_valid); end
    tick();
    checks++; if (if1.out_valid !== 1'b1 || if1.p !== -35'sd2) begin failures++; $display("FAIL round_m25 got=%0d/%0b exp=-2/1", if1.p, if1.out_valid); end
    checks++; if (if1.ovf !== 1'b0) begin failures++; $display("FAIL round_ovf got=%0b exp=0", if1.ovf); end
    idle(2);
  endtask

  // Six accumulate samples with ce low for cycles 4..6. During the stall,
  // junk valid samples are driven. They must not be captured.
  task automatic test_ce_stall();
    bit     ev;
    bit     chk_p;
    longint ep;
    for (int c = 0; c < 13; c++) begin
      ce = 1'b1;
      case (c)
        0: drive0(1, 1, 2, 1, 1);
        1: drive0(1, 3, 4, 1, 0);
        2: drive0(1, -5, 6, 1, 0);
        3: drive0(1, 7, -8, 1, 0);
        4, 5, 6: begin ce = 1'b0; drive0(1, 99, 99, 1, 0); end
        7: drive0(1, 2, 2, 1, 0);
        8: drive0(1, 10, 10, 1, 0);
        default: drive0(0, 0, 0, 0, 0);
      endcase
      tick();
      ev = 1'b0; chk_p = 1'b1; ep = 0;
      case (c)
        0, 1, 2: chk_p = 1'b0;
        3, 4, 5, 6: begin ev = 1; ep = 2; end
        7:  begin ev = 1; ep = 14;  end
        8:  begin ev = 1; ep = -16; end
        9:  begin ev = 1; ep = -72; end
        10: begin ev = 1; ep = -68; end
        11: begin ev = 1; ep = 32;  end
        default: ep = 32;
      endcase
      checks++;
      if (if0.out_valid !== ev) begin failures++; $display("FAIL stall_valid c=%0d got=%0b exp=%0b", c, if0.out_valid, ev); end
      if (chk_p) begin
        checks++;
        if (if0.p !== 35'(ep)) begin failures++; $display("FAIL stall_p c=%0d got=%0d exp=%0d", c, if0.p, ep); end
      end
    end
    ce = 1'b1;
    idle(2);
  endtask

  task automatic test_reset_mid();
    drive0(1, 5, 5, 1, 1); tick();
    drive0(1, 6, 6, 1, 0); tick();
    drive0(1, 7, 7, 1, 0); tick();
    drive0(1, 8, 8, 1, 0); tick();
    drive0(0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%0b exp=0", if0.out_valid); end
    checks++; if (if0.p !== 35'sd0) begin failures++; $display("FAIL rmid_p got=%0d exp=0", if0.p); end
    checks++; if (if0.ovf !== 1'b0) begin failures++; $display("FAIL rmid_ovf got=%0b exp=0", if0.ovf); end
    drive0(1, 3, 3, 1, 0); tick();
    drive0(0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL rmid_flush c=%0d got=%0b exp=0", c, if0.out_valid); end
    end
    tick();
    checks++; if (if0.out_valid !== 1'b1 || if0.p !== 35'sd9) begin failures++; $display("FAIL rmid_post got=%0d/%0b exp=9/1", if0.p, if0.out_valid); end
    idle(2);
  endtask

  initial begin
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    test_reset();
    test_plain_mult();
    test_accumulate(1'b0);
    idle(2);
    test_accumulate(1'b1);
    idle(2);
    test_saturation();
    test_rounding();
    test_ce_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
